// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, frame constants and baud divider helper
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // Integer truncation: the actual baud rate may be slightly above nominal.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing a one-cycle tick at terminal count
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with registered line and busy outputs
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       tx_out,
    output logic       tx_busy
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_next;
    logic                 tx_out_next;
    logic                 tx_busy_next;
    logic                 baud_clear;
    logic                 bit_tick;

    // Holding the divider cleared in IDLE makes every bit period start at zero.
    assign baud_clear = (state == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx_out    <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_idx_next;
            tx_out    <= tx_out_next;
            tx_busy   <= tx_busy_next;
        end
    end

    // Outputs are computed from the next state so they register on the same edge.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx;
        tx_out_next  = tx_out;
        tx_busy_next = tx_busy;
        case (state)
            IDLE: begin
                tx_out_next  = 1'b1;
                tx_busy_next = 1'b0;
                if (tx_start) begin
                    state_next   = START;
                    shift_next   = data_in;
                    bit_idx_next = '0;
                    tx_out_next  = 1'b0;
                    tx_busy_next = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_next  = DATA;
                    tx_out_next = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx == LAST_BIT) begin
                        state_next  = STOP;
                        tx_out_next = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        tx_out_next  = shift_next[0];
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_next   = IDLE;
                    tx_out_next  = 1'b1;
                    tx_busy_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized scoreboard bench for uart_tx
module tb_uart_tx;

    localparam int CLK_FREQ  = 50000000;
    localparam int BAUD_RATE = 115200;
    localparam int N         = CLK_FREQ / BAUD_RATE;
    localparam int FRAME     = 10 * N;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       tx_out;
    logic       tx_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        int         edge_c;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   edge_n  = 0;
    int   free_at = 0;

    bit         in_frame = 1'b0;
    int         k        = 0;
    logic [9:0] frame_bits;
    bit         bad_out;
    bit         bad_busy;
    logic       act_out;
    logic       act_busy;

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_start(tx_start),
        .data_in (data_in),
        .tx_out  (tx_out),
        .tx_busy (tx_busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: a request is taken when the line has been free since the
    // previous frame's 10 bit periods plus the one idle cycle.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (!rst_n) begin
            exp_q.delete();
            free_at = 0;
        end else if (tx_start && edge_n >= free_at) begin
            exp_q.push_back('{data: data_in, edge_c: edge_n});
            free_at = edge_n + FRAME + 1;
        end
    end

    task automatic sample_bit();
        int b = k / N;
        if (tx_out !== frame_bits[b]) begin
            bad_out = 1'b1;
            act_out = tx_out;
        end
        if (tx_busy !== 1'b1) begin
            bad_busy = 1'b1;
            act_busy = tx_busy;
        end
        if (k % N == N - 1) begin
            checks += 2;
            if (bad_out) begin
                failures++;
                $display("FAIL line_bit%0d actual=%b required=%b", b, act_out, frame_bits[b]);
            end
            if (bad_busy) begin
                failures++;
                $display("FAIL busy_bit%0d actual=%b required=1", b, act_busy);
            end
            bad_out  = 1'b0;
            bad_busy = 1'b0;
        end
        k++;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            check("reset_tx_out", tx_out, 1);
            check("reset_tx_busy", tx_busy, 0);
        end else if (in_frame) begin
            if (k < FRAME) begin
                sample_bit();
            end else begin
                check("end_tx_busy", tx_busy, 0);
                check("end_tx_out", tx_out, 1);
                in_frame = 1'b0;
            end
        end else if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame actual=out%b_busy%b required=idle", tx_out, tx_busy);
                frame_bits = {1'b1, 8'h00, 1'b0};
            end else begin
                cur = exp_q.pop_front();
                check("start_edge", edge_n, cur.edge_c);
                frame_bits = {1'b1, cur.data, 1'b0};
            end
            in_frame = 1'b1;
            k        = 0;
            bad_out  = 1'b0;
            bad_busy = 1'b0;
            sample_bit();
        end else if (exp_q.size() > 0 && edge_n > exp_q[0].edge_c) begin
            check("missing_frame_busy", tx_busy, 1);
            void'(exp_q.pop_front());
        end
    end

    task automatic tick(input int n, input bit scramble);
        repeat (n) begin
            @(negedge clk);
            if (scramble) data_in = 8'($urandom);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_start = 1'b1;
        data_in  = b;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(edge_n >= free_at && !in_frame) && n < 3 * FRAME) begin
            @(negedge clk);
            data_in = 8'($urandom);
            n++;
        end
        checks++;
        if (n >= 3 * FRAME) begin
            failures++;
            $display("FAIL wait_idle_timeout actual=%0d cycles required<%0d", n, 3 * FRAME);
        end
        tick(2, 1'b1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset_async_out", tx_out, 1);
        check("reset_async_busy", tx_busy, 0);
        #100;
        @(negedge clk);
        rst_n = 1'b1;
        tick(20, 1'b1);
        check("post_reset_out", tx_out, 1);
        check("post_reset_busy", tx_busy, 0);

        send(8'h41);
        wait_idle();

        tick(50, 1'b1);
        send(8'h42);
        wait_idle();

        send(8'h00);
        tick(2000, 1'b1);
        @(negedge clk);
        tx_start = 1'b1;
        data_in  = 8'hFF;
        @(negedge clk);
        tx_start = 1'b0;
        wait_idle();
        tick(30, 1'b1);

        send(8'h55);
        tick(4 * N + N / 2, 1'b1);
        check("pre_reset_busy", tx_busy, 1);
        check("pre_reset_bit3", tx_out, 0);
        #5 rst_n = 1'b0;
        #1;
        check("midframe_reset_out", tx_out, 1);
        check("midframe_reset_busy", tx_busy, 0);
        tick(3, 1'b0);
        rst_n = 1'b1;
        tick(20, 1'b1);
        check("after_abort_out", tx_out, 1);
        check("after_abort_busy", tx_busy, 0);

        @(negedge clk);
        tx_start = 1'b1;
        data_in  = 8'hA5;
        tick(5 * N, 1'b0);
        data_in = 8'h3C;
        tick(5 * N + 10, 1'b0);
        tx_start = 1'b0;
        wait_idle();

        for (int i = 0; i < 4; i++) begin
            tick($urandom_range(0, 3000), 1'b1);
            @(negedge clk);
            tx_start = 1'b1;
            data_in  = 8'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                data_in = 8'($urandom);
            end
            @(negedge clk);
            tx_start = 1'b0;
        end
        wait_idle();

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
